// File: rtl/step_clock_gen_if.sv
// Transport-control inputs and step-index outputs shared between the step clock
// generator (master) and the note-trigger decoder / host control (slave).
interface step_clock_gen_if #(
  parameter int DIV_WIDTH = 24
);
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic [DIV_WIDTH-1:0] tempo_div;
  logic                 tempo_load;
  logic [3:0]           length;
  logic [3:0]           counter;
  logic                 step_tick;
  logic                 wrap;
  logic                 running;

  modport master (
    input  start, stop, pause, tempo_div, tempo_load, length,
    output counter, step_tick, wrap, running
  );

  modport slave (
    output start, stop, pause, tempo_div, tempo_load, length,
    input  counter, step_tick, wrap, running
  );
endinterface

// File: rtl/step_clock_gen.sv
// Tempo divider and step-index sequencer with start/stop/pause transport and
// registered one-cycle step/wrap strobes for the note-trigger decoder.
module step_clock_gen #(
  parameter int                   DIV_WIDTH   = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd6_250_000,
  parameter int                   MIN_DIV     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  step_clock_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [DIV_WIDTH-1:0] presc_reg, presc_next;
  logic [3:0]           counter_reg, counter_next;
  logic                 tick_reg, tick_next;
  logic                 wrap_reg, wrap_next;

  // State register (plus datapath registers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_reg     <= DEFAULT_DIV;
      presc_reg   <= '0;
      counter_reg <= 4'd0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      presc_reg   <= presc_next;
      counter_reg <= counter_next;
      tick_reg    <= tick_next;
      wrap_reg    <= wrap_next;
    end
  end

  // Next-state logic: stop beats start beats pause
  always_comb begin
    state_next = state_reg;
    if (bus.stop) begin
      state_next = IDLE;
    end else if (bus.start) begin
      state_next = RUN;
    end else if (bus.pause) begin
      case (state_reg)
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = state_reg;
      endcase
    end
  end

  // Datapath next values; a pause edge freezes presc/counter in either direction
  always_comb begin
    div_next     = div_reg;
    presc_next   = presc_reg;
    counter_next = counter_reg;
    tick_next    = 1'b0;
    wrap_next    = 1'b0;

    if (bus.tempo_load) begin
      div_next = (bus.tempo_div < MIN_DIV_W) ? MIN_DIV_W : bus.tempo_div;
    end

    if (bus.stop) begin
      counter_next = 4'd0;
      presc_next   = '0;
    end else if (bus.start) begin
      counter_next = 4'd0;
      presc_next   = div_reg - ONE_W;
      tick_next    = 1'b1;
    end else if (!bus.pause && state_reg == RUN) begin
      if (presc_reg == '0) begin
        // Reload uses the pre-load divider, so a same-cycle load applies one step later
        presc_next = div_reg - ONE_W;
        tick_next  = 1'b1;
        if (counter_reg >= bus.length) begin
          counter_next = 4'd0;
          wrap_next    = 1'b1;
        end else begin
          counter_next = counter_reg + 4'd1;
        end
      end else begin
        presc_next = presc_reg - ONE_W;
      end
    end
  end

  // Output logic
  always_comb begin
    bus.running   = (state_reg == RUN);
    bus.counter   = counter_reg;
    bus.step_tick = tick_reg;
    bus.wrap      = wrap_reg;
  end
endmodule

// File: tb/tb_step_clock_gen.sv
// Directed test of step_clock_gen: transport control, pause freeze, length
// change, divider clamp/load timing and asynchronous reset.
module tb_step_clock_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  step_clock_gen_if #(.DIV_WIDTH(24)) bus ();

  step_clock_gen #(
    .DIV_WIDTH(24),
    .DEFAULT_DIV(24'd10),
    .MIN_DIV(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a tick is seen; n = steps taken, 0 on timeout
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (bus.step_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int ticks;
    bus.start = 0; bus.stop = 0; bus.pause = 0;
    bus.tempo_div = '0; bus.tempo_load = 0; bus.length = 4'd3;
    rst_n = 0;
    step(); step();
    total++; if (bus.counter !== 4'd0) begin bad++; $display("FAIL reset_counter got=%0d exp=0", bus.counter); end
    total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.step_tick); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    rst_n = 1;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin step(); if (bus.step_tick === 1'b1) ticks++; end
    total++; if (ticks !== 0) begin bad++; $display("FAIL reset_idle_ticks got=%0d exp=0", ticks); end
    bus.start = 1; step(); bus.start = 0;
    total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL reset_first_tick got=%b exp=1", bus.step_tick); end
    wait_tick(n);
    total++; if (n !== 10) begin bad++; $display("FAIL reset_default_period got=%0d exp=10", n); end
    bus.stop = 1; step(); bus.stop = 0;
    $display("test_reset done");
  endtask

  task automatic test_basic_run();
    bus.tempo_div = 24'd4; bus.tempo_load = 1; step(); bus.tempo_load = 0;
    bus.length = 4'd3;
    bus.start = 1; step(); bus.start = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) step();
      total++; if (bus.step_tick !== (((k - 1) % 4) == 0)) begin bad++; $display("FAIL run_tick k=%0d got=%b", k, bus.step_tick); end
      total++; if (bus.counter !== 4'(((k - 1) / 4) % 4)) begin bad++; $display("FAIL run_counter k=%0d got=%0d exp=%0d", k, bus.counter, ((k - 1) / 4) % 4); end
      total++; if (bus.wrap !== (k == 17)) begin bad++; $display("FAIL run_wrap k=%0d got=%b exp=%b", k, bus.wrap, k == 17); end
      total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL run_running k=%0d got=%b exp=1", k, bus.running); end
    end
    $display("test_basic_run done");
  endtask

  task automatic test_pause();
    int ticks;
    int changes;
    logic [3:0] frozen;
    step(); step();
    bus.pause = 1; step(); bus.pause = 0;
    frozen = bus.counter;
    total++; if (frozen !== 4'd0) begin bad++; $display("FAIL pause_counter got=%0d exp=0", frozen); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", bus.running); end
    ticks = 0; changes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.step_tick === 1'b1) ticks++;
      if (bus.counter !== frozen) changes++;
    end
    total++; if (ticks !== 0) begin bad++; $display("FAIL pause_ticks got=%0d exp=0", ticks); end
    total++; if (changes !== 0) begin bad++; $display("FAIL pause_frozen got=%0d exp=0", changes); end
    bus.pause = 1; step(); bus.pause = 0;
    total++; if (bus.running !== 1'b1 || bus.step_tick !== 1'b0) begin bad++; $display("FAIL resume_edge running=%b tick=%b exp 1/0", bus.running, bus.step_tick); end
    step();
    total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL resume_plus1 tick=%b exp=0", bus.step_tick); end
    step();
    total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL resume_plus2 tick=%b exp=1", bus.step_tick); end
    total++; if (bus.counter !== 4'd1) begin bad++; $display("FAIL resume_counter got=%0d exp=1", bus.counter); end
    $display("test_pause done");
  endtask

  task automatic test_length();
    int n;
    bus.length = 4'd15;
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.counter === 4'd9) break;
      wait_tick(n);
    end
    total++; if (bus.counter !== 4'd9) begin bad++; $display("FAIL len_reach9 got=%0d exp=9", bus.counter); end
    bus.length = 4'd5;
    wait_tick(n);
    total++; if (n !== 4) begin bad++; $display("FAIL len_period got=%0d exp=4", n); end
    total++; if (bus.counter !== 4'd0 || bus.wrap !== 1'b1) begin bad++; $display("FAIL len_shrink_wrap counter=%0d wrap=%b exp 0/1", bus.counter, bus.wrap); end
    for (int k = 1; k <= 5; k++) begin
      wait_tick(n);
      total++; if (bus.counter !== 4'(k) || bus.wrap !== 1'b0) begin bad++; $display("FAIL len_seq k=%0d counter=%0d wrap=%b", k, bus.counter, bus.wrap); end
    end
    wait_tick(n);
    total++; if (bus.counter !== 4'd0 || bus.wrap !== 1'b1) begin bad++; $display("FAIL len_rewrap counter=%0d wrap=%b exp 0/1", bus.counter, bus.wrap); end
    bus.length = 4'd0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      total++; if (n !== 4 || bus.counter !== 4'd0 || bus.wrap !== 1'b1) begin bad++; $display("FAIL len_zero k=%0d n=%0d counter=%0d wrap=%b exp 4/0/1", k, n, bus.counter, bus.wrap); end
    end
    bus.length = 4'd5;
    $display("test_length done");
  endtask

  task automatic test_tempo();
    int n;
    bus.tempo_div = 24'd1; bus.tempo_load = 1; step(); bus.tempo_load = 0;
    wait_tick(n);
    total++; if (n !== 3) begin bad++; $display("FAIL tempo_old_period got=%0d exp=3", n); end
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      total++; if (n !== 2) begin bad++; $display("FAIL tempo_clamped k=%0d got=%0d exp=2", k, n); end
    end
    bus.tempo_div = 24'd8; bus.tempo_load = 1; step(); bus.tempo_load = 0;
    wait_tick(n);
    total++; if (n !== 1) begin bad++; $display("FAIL tempo8_current got=%0d exp=1", n); end
    for (int k = 0; k < 2; k++) begin
      wait_tick(n);
      total++; if (n !== 8) begin bad++; $display("FAIL tempo8_period k=%0d got=%0d exp=8", k, n); end
    end
    for (int i = 0; i < 7; i++) step();
    bus.tempo_div = 24'd3; bus.tempo_load = 1; step(); bus.tempo_load = 0;
    total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL tempo_coincide_tick got=%b exp=1", bus.step_tick); end
    wait_tick(n);
    total++; if (n !== 8) begin bad++; $display("FAIL tempo_coincide_old got=%0d exp=8", n); end
    wait_tick(n);
    total++; if (n !== 3) begin bad++; $display("FAIL tempo_coincide_new got=%0d exp=3", n); end
    $display("test_tempo done");
  endtask

  task automatic test_stop();
    int n;
    int ticks;
    wait_tick(n);
    bus.start = 1; bus.stop = 1; step(); bus.start = 0; bus.stop = 0;
    total++; if (bus.running !== 1'b0 || bus.counter !== 4'd0 || bus.step_tick !== 1'b0) begin bad++; $display("FAIL stop_start running=%b counter=%0d tick=%b exp 0/0/0", bus.running, bus.counter, bus.step_tick); end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin step(); if (bus.step_tick === 1'b1) ticks++; end
    total++; if (ticks !== 0) begin bad++; $display("FAIL stop_idle_ticks got=%0d exp=0", ticks); end
    bus.start = 1; step(); bus.start = 0;
    wait_tick(n);
    total++; if (n !== 3 || bus.counter !== 4'd1) begin bad++; $display("FAIL stop_restart n=%0d counter=%0d exp 3/1", n, bus.counter); end
    bus.pause = 1; step(); bus.pause = 0;
    total++; if (bus.running !== 1'b0 || bus.counter !== 4'd1) begin bad++; $display("FAIL stop_paused running=%b counter=%0d exp 0/1", bus.running, bus.counter); end
    bus.stop = 1; step(); bus.stop = 0;
    total++; if (bus.counter !== 4'd0 || bus.step_tick !== 1'b0) begin bad++; $display("FAIL stop_from_pause counter=%0d tick=%b exp 0/0", bus.counter, bus.step_tick); end
    bus.pause = 1; step(); bus.pause = 0;
    ticks = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus.step_tick === 1'b1 || bus.running === 1'b1) ticks++; end
    total++; if (ticks !== 0) begin bad++; $display("FAIL stop_pause_in_idle got=%0d exp=0", ticks); end
    $display("test_stop done");
  endtask

  task automatic test_async_reset();
    int n;
    int ticks;
    bus.start = 1; step(); bus.start = 0;
    wait_tick(n);
    step();
    total++; if (bus.running !== 1'b1 || bus.counter !== 4'd1) begin bad++; $display("FAIL areset_pre running=%b counter=%0d exp 1/1", bus.running, bus.counter); end
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    total++; if (bus.running !== 1'b0 || bus.counter !== 4'd0 || bus.step_tick !== 1'b0 || bus.wrap !== 1'b0) begin bad++; $display("FAIL areset_now running=%b counter=%0d tick=%b wrap=%b exp 0", bus.running, bus.counter, bus.step_tick, bus.wrap); end
    rst_n = 1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.step_tick === 1'b1 || bus.running === 1'b1) ticks++; end
    total++; if (ticks !== 0) begin bad++; $display("FAIL areset_quiet got=%0d exp=0", ticks); end
    bus.start = 1; step(); bus.start = 0;
    total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL areset_start_tick got=%b exp=1", bus.step_tick); end
    wait_tick(n);
    total++; if (n !== 10) begin bad++; $display("FAIL areset_default_div got=%0d exp=10", n); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_pause();
    test_length();
    test_tempo();
    test_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
